// File: rtl/cpu_run_ctrl.sv
// Run controller for the cpu core: sequences core reset, drives alternating
// read/write phase enables, counts run cycles and ends the run on halt or budget.
module cpu_run_ctrl #(
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 30,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             restart,
  output logic             cpu_rst,
  output logic             phase_read,
  output logic             phase_write,
  output logic [CNT_W-1:0] cycle_count,
  output logic             halted,
  output logic             timeout,
  output logic             sim_end,
  output logic [1:0]       run_state
);

  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam logic [RW-1:0]    RESET_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] COUNT_MAX  = CNT_W'(MAX_CYCLES);

  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("cpu_run_ctrl: RESET_CYCLES must be >= 1");
  end
  if (MAX_CYCLES < 1) begin : g_bad_max_cycles
    $error("cpu_run_ctrl: MAX_CYCLES must be >= 1");
  end
  if ((64'd1 << CNT_W) <= 64'(MAX_CYCLES)) begin : g_bad_cnt_w
    $error("cpu_run_ctrl: CNT_W too narrow to hold MAX_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [RW-1:0] rst_cnt;

  // Exposes the controller state for checkers and debug probes.
  assign run_state = state;

  // Handshakes: halt is only honoured in RUN, restart only in DONE; both are
  // level-sampled on the rising edge and need no acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RESET;
      rst_cnt     <= '0;
      cpu_rst     <= 1'b1;
      phase_read  <= 1'b0;
      phase_write <= 1'b0;
      cycle_count <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      sim_end     <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          if (rst_cnt == RESET_LAST) begin
            state       <= ST_RUN;
            cpu_rst     <= 1'b0;
            phase_read  <= 1'b1;
            phase_write <= 1'b0;
            cycle_count <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          // Halt takes priority over budget exhaustion on the same edge.
          if (halt) begin
            state       <= ST_DONE;
            halted      <= 1'b1;
            sim_end     <= 1'b1;
            phase_read  <= 1'b0;
            phase_write <= 1'b0;
          end else if (cycle_count == COUNT_LAST) begin
            state       <= ST_DONE;
            cycle_count <= COUNT_MAX;
            timeout     <= 1'b1;
            sim_end     <= 1'b1;
            phase_read  <= 1'b0;
            phase_write <= 1'b0;
          end else begin
            cycle_count <= cycle_count + 1'b1;
            phase_read  <= ~phase_read;
            phase_write <= ~phase_write;
          end
        end

        ST_DONE: begin
          if (restart) begin
            state       <= ST_RESET;
            rst_cnt     <= '0;
            cpu_rst     <= 1'b1;
            cycle_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            sim_end     <= 1'b0;
          end
        end

        default: begin
          state       <= ST_RESET;
          rst_cnt     <= '0;
          cpu_rst     <= 1'b1;
          phase_read  <= 1'b0;
          phase_write <= 1'b0;
          cycle_count <= '0;
          halted      <= 1'b0;
          timeout     <= 1'b0;
          sim_end     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random stimulus, all checked
// against a run-level model (reset edges seen, run edges counted, end reason).
module tb_cpu_run_ctrl;
  localparam int R   = 2;
  localparam int M   = 30;
  localparam int CW  = 16;
  localparam int OW  = 6 + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          halt = 1'b0;
  logic          restart = 1'b0;
  logic          cpu_rst, phase_read, phase_write, halted, timeout, sim_end;
  logic [CW-1:0] cycle_count;
  logic [1:0]    run_state;
  logic [OW-1:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = core held in reset, 1 = running, 2 = finished.
  int m_mode = 0;
  int m_rcnt = 0;
  int m_runs = 0;
  bit m_halted = 1'b0;
  bit m_timeout = 1'b0;

  cpu_run_ctrl #(.RESET_CYCLES(R), .MAX_CYCLES(M), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .halt(halt), .restart(restart),
    .cpu_rst(cpu_rst), .phase_read(phase_read), .phase_write(phase_write),
    .cycle_count(cycle_count), .halted(halted), .timeout(timeout),
    .sim_end(sim_end), .run_state(run_state)
  );

  always #5 clk = ~clk;

  assign obs = {cpu_rst, phase_read, phase_write, halted, timeout, sim_end, cycle_count};

  function automatic logic [OW-1:0] exp_vec();
    logic in_run;
    in_run  = (m_mode == 1);
    exp_vec = {m_mode == 0, in_run && (m_runs % 2 == 0), in_run && (m_runs % 2 == 1),
               m_halted, m_timeout, m_mode == 2, CW'(m_runs)};
  endfunction

  task automatic model_step(input logic r, input logic h, input logic s);
    if (r) begin
      m_mode = 0; m_rcnt = 0; m_runs = 0; m_halted = 0; m_timeout = 0;
    end else if (m_mode == 0) begin
      m_rcnt++;
      if (m_rcnt == R) begin
        m_mode = 1; m_runs = 0;
      end
    end else if (m_mode == 1) begin
      if (h) begin
        m_mode = 2; m_halted = 1;
      end else if (m_runs + 1 == M) begin
        m_mode = 2; m_runs = M; m_timeout = 1;
      end else begin
        m_runs++;
      end
    end else if (s) begin
      m_mode = 0; m_rcnt = 0; m_runs = 0; m_halted = 0; m_timeout = 0;
    end
  endtask

  task automatic tick(input logic r, input logic h, input logic s);
    rst = r; halt = h; restart = s;
    @(posedge clk);
    model_step(r, h, s);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0);
    tick(1, 0, 0);
    n_checks++;
    if (obs !== {6'b100000, CW'(0)}) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", obs, {6'b100000, CW'(0)});
    end
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_timeout();
    int k;
    tick(0, 0, 0);
    n_checks++;
    if (cpu_rst !== 1'b1) begin
      n_fail++; $display("FAIL cpu_rst_hold: got %b expected 1", cpu_rst);
    end
    tick(0, 0, 0);
    n_checks++;
    if ({cpu_rst, phase_read, phase_write} !== 3'b010) begin
      n_fail++; $display("FAIL run_entry: got %b expected 010", {cpu_rst, phase_read, phase_write});
    end
    k = 0;
    while (sim_end !== 1'b1 && k < M + 10) begin
      tick(0, 0, 0);
      k++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL timeout_run k=%0d: got %h expected %h", k, obs, exp_vec());
      end
    end
    n_checks++;
    if (k !== M) begin
      n_fail++; $display("FAIL timeout_edges: got %0d expected %0d", k, M);
    end
    n_checks++;
    if ({halted, timeout, sim_end, cycle_count} !== {3'b011, CW'(M)}) begin
      n_fail++; $display("FAIL timeout_flags: got %h expected %h",
                         {halted, timeout, sim_end, cycle_count}, {3'b011, CW'(M)});
    end
  endtask

  task automatic test_halt(input int target, input string name);
    int k;
    tick(0, 0, 1);
    k = 0;
    while (!(m_mode == 1 && m_runs == target) && k < M + 10) begin
      tick(0, 0, 0);
      k++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL %s_approach: got %h expected %h", name, obs, exp_vec());
      end
    end
    tick(0, 1, 0);
    n_checks++;
    if ({phase_read, phase_write, halted, timeout, sim_end, cycle_count} !== {5'b00101, CW'(target)}) begin
      n_fail++; $display("FAIL %s: got %h expected %h", name,
                         {phase_read, phase_write, halted, timeout, sim_end, cycle_count},
                         {5'b00101, CW'(target)});
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 1'($urandom_range(0, 1)), 0);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL %s_hold: got %h expected %h", name, obs, exp_vec());
      end
    end
  endtask

  task automatic test_restart();
    int k;
    tick(0, 0, 1);
    n_checks++;
    if (obs !== {6'b100000, CW'(0)}) begin
      n_fail++; $display("FAIL restart_clear: got %h expected %h", obs, {6'b100000, CW'(0)});
    end
    k = 0;
    while (sim_end !== 1'b1 && k < M + R + 10) begin
      tick(0, 0, 1'($urandom_range(0, 1)));
      k++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL restart_run k=%0d: got %h expected %h", k, obs, exp_vec());
      end
    end
    n_checks++;
    if (k !== M + R || cycle_count !== CW'(M) || timeout !== 1'b1) begin
      n_fail++; $display("FAIL restart_second_run: got edges=%0d count=%0d to=%b expected edges=%0d count=%0d to=1",
                         k, cycle_count, timeout, M + R, M);
    end
  endtask

  task automatic test_rst_mid_run();
    int k;
    tick(0, 0, 1);
    k = 0;
    while (!(m_mode == 1 && m_runs == 12) && k < M + 10) begin
      tick(0, 0, 0);
      k++;
    end
    tick(1, 0, 0);
    n_checks++;
    if (obs !== {6'b100000, CW'(0)}) begin
      n_fail++; $display("FAIL rst_mid_run: got %h expected %h", obs, {6'b100000, CW'(0)});
    end
    k = 0;
    while (sim_end !== 1'b1 && k < M + R + 10) begin
      tick(0, 0, 0);
      k++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL rst_recover k=%0d: got %h expected %h", k, obs, exp_vec());
      end
    end
    n_checks++;
    if (k !== M + R || {timeout, cycle_count} !== {1'b1, CW'(M)}) begin
      n_fail++; $display("FAIL rst_recover_end: got edges=%0d to=%b count=%0d expected %0d 1 %0d",
                         k, timeout, cycle_count, M + R, M);
    end
  endtask

  task automatic test_halt_through_reset();
    tick(1, 1, 0);
    for (int i = 0; i < R; i++) begin
      tick(0, 1, 0);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL halt_in_reset %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    tick(0, 1, 0);
    n_checks++;
    if (obs !== {6'b000101, CW'(0)}) begin
      n_fail++; $display("FAIL halt_first_run_edge: got %h expected %h", obs, {6'b000101, CW'(0)});
    end
  endtask

  task automatic test_random();
    logic r, h, s;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 99) == 0);
      h = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 3) == 0);
      tick(r, h, s);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random %0d: got %h expected %h", i, obs, exp_vec());
      end
      n_checks++;
      if ((halted & timeout) || (sim_end !== (halted | timeout))) begin
        n_fail++; $display("FAIL random_flags %0d: got h=%b t=%b e=%b", i, halted, timeout, sim_end);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_halt(5, "halt_at_5");
    test_halt(M - 1, "halt_at_budget");
    test_halt($urandom_range(0, M - 1), "halt_random");
    test_restart();
    test_rst_mid_run();
    test_halt_through_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
